// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types and constants for the SDRAM command-port arbiter.
// Port indices double as holding-buffer indices.
package sdram_arb_pkg;

  localparam int DEF_ADDR_W = 25;
  localparam int DEF_DATA_W = 128;

  localparam logic [1:0] PORT_RD  = 2'd0;
  localparam logic [1:0] PORT_CAM = 2'd1;
  localparam logic [1:0] PORT_HDR = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_WR,
    WAIT_RD
  } arb_state_e;

endpackage

// File: rtl/sdram_port_arbiter_buf.sv
// One-entry request holding register for one arbiter port.
// Requests that find it full, or arrive while it drains, are dropped.
module arb_port_buf
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              clr_i,
  output logic              full_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              ovf_o
);

  logic              full_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (clr_i) full_q <= 1'b0;
      // clr_i only fires while full, so this also drops same-cycle refills
      if (req_i) begin
        if (full_q) begin
          ovf_q <= 1'b1;
        end else begin
          full_q <= 1'b1;
          addr_q <= addr_i;
          data_q <= data_i;
        end
      end
    end
  end

  assign full_o = full_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Three-port arbiter in front of a single SDRAM controller command port.
// Reads win until the streak cap; writers alternate round-robin.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int MAX_RD_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_busy,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              cam_wr_req,
  input  logic [ADDR_W-1:0] cam_wr_addr,
  input  logic [DATA_W-1:0] cam_wr_data,
  output logic              cam_busy,
  input  logic              hdr_wr_req,
  input  logic [ADDR_W-1:0] hdr_wr_addr,
  input  logic [DATA_W-1:0] hdr_wr_data,
  output logic              hdr_busy,
  input  logic              ctrl_busy,
  input  logic              ctrl_rd_valid,
  input  logic [DATA_W-1:0] ctrl_rd_data,
  output logic              ctrl_cmd_valid,
  output logic              ctrl_cmd_wr,
  output logic [ADDR_W-1:0] ctrl_addr,
  output logic [DATA_W-1:0] ctrl_wr_data,
  output logic [2:0]        overflow
);

  localparam int SW = $clog2(MAX_RD_STREAK + 1);

  logic [2:0]        full;
  logic [2:0]        clr;
  logic [ADDR_W-1:0] b_addr [3];
  logic [DATA_W-1:0] b_data [3];

  arb_port_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (rd_req),
    .addr_i (rd_addr),
    .data_i ('0),
    .clr_i  (clr[0]),
    .full_o (full[0]),
    .addr_o (b_addr[0]),
    .data_o (b_data[0]),
    .ovf_o  (overflow[0])
  );

  arb_port_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cam (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (cam_wr_req),
    .addr_i (cam_wr_addr),
    .data_i (cam_wr_data),
    .clr_i  (clr[1]),
    .full_o (full[1]),
    .addr_o (b_addr[1]),
    .data_o (b_data[1]),
    .ovf_o  (overflow[1])
  );

  arb_port_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_hdr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (hdr_wr_req),
    .addr_i (hdr_wr_addr),
    .data_i (hdr_wr_data),
    .clr_i  (clr[2]),
    .full_o (full[2]),
    .addr_o (b_addr[2]),
    .data_o (b_data[2]),
    .ovf_o  (overflow[2])
  );

  arb_state_e        state_q;
  logic [1:0]        win_q;
  logic [SW-1:0]     streak_q;
  logic              rr_q;
  logic              guard_q;
  logic              cmd_valid_q;
  logic              cmd_wr_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_data_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  logic              wr_pend;
  logic              rd_ok;
  logic [1:0]        pick;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  assign wr_pend = full[1] | full[2];
  assign rd_ok   = full[0] &&
                   !(wr_pend && streak_q == SW'(MAX_RD_STREAK));

  always_comb begin
    pick = PORT_RD;
    if (rd_ok)
      pick = PORT_RD;
    else if (full[1] && full[2])
      pick = rr_q ? PORT_HDR : PORT_CAM;
    else if (full[1])
      pick = PORT_CAM;
    else if (full[2])
      pick = PORT_HDR;
  end

  always_comb begin
    sel_addr = b_addr[0];
    sel_data = b_data[0];
    unique case (1'b1)
      pick == PORT_CAM: begin
        sel_addr = b_addr[1];
        sel_data = b_data[1];
      end
      pick == PORT_HDR: begin
        sel_addr = b_addr[2];
        sel_data = b_data[2];
      end
      default: ;
    endcase
  end

  assign clr = (state_q == ISSUE) ? (3'b001 << win_q) : 3'b000;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      win_q       <= PORT_RD;
      streak_q    <= '0;
      rr_q        <= 1'b0;
      guard_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      cmd_valid_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      if (!wr_pend) streak_q <= '0;
      unique case (state_q)
        IDLE: begin
          if ((|full) && !ctrl_busy) begin
            win_q       <= pick;
            cmd_valid_q <= 1'b1;
            cmd_wr_q    <= (pick != PORT_RD);
            cmd_addr_q  <= sel_addr;
            cmd_data_q  <= sel_data;
            if (pick == PORT_RD) begin
              if (wr_pend) streak_q <= streak_q + SW'(1);
            end else begin
              streak_q <= '0;
              rr_q     <= ~rr_q;
            end
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          guard_q <= 1'b1;
          state_q <= cmd_wr_q ? WAIT_WR : WAIT_RD;
        end
        WAIT_WR: begin
          // controller may not raise busy until a cycle after the strobe
          if (guard_q)
            guard_q <= 1'b0;
          else if (!ctrl_busy)
            state_q <= IDLE;
        end
        WAIT_RD: begin
          if (ctrl_rd_valid) begin
            rd_data_q  <= ctrl_rd_data;
            rd_valid_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_busy        = full[0];
  assign cam_busy       = full[1];
  assign hdr_busy       = full[2];
  assign rd_data        = rd_data_q;
  assign rd_valid       = rd_valid_q;
  assign ctrl_cmd_valid = cmd_valid_q;
  assign ctrl_cmd_wr    = cmd_wr_q;
  assign ctrl_addr      = cmd_addr_q;
  assign ctrl_wr_data   = cmd_data_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter with a small controller model.
// Expected commands and read data are queued; a monitor pops and compares.
module tb_sdram_port_arbiter;

  localparam int AW = 25;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_busy;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          cam_wr_req;
  logic [AW-1:0] cam_wr_addr;
  logic [DW-1:0] cam_wr_data;
  logic          cam_busy;
  logic          hdr_wr_req;
  logic [AW-1:0] hdr_wr_addr;
  logic [DW-1:0] hdr_wr_data;
  logic          hdr_busy;
  logic          ctrl_busy;
  logic          ctrl_rd_valid;
  logic [DW-1:0] ctrl_rd_data;
  logic          ctrl_cmd_valid;
  logic          ctrl_cmd_wr;
  logic [AW-1:0] ctrl_addr;
  logic [DW-1:0] ctrl_wr_data;
  logic [2:0]    overflow;

  sdram_port_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_busy        (rd_busy),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .cam_wr_req     (cam_wr_req),
    .cam_wr_addr    (cam_wr_addr),
    .cam_wr_data    (cam_wr_data),
    .cam_busy       (cam_busy),
    .hdr_wr_req     (hdr_wr_req),
    .hdr_wr_addr    (hdr_wr_addr),
    .hdr_wr_data    (hdr_wr_data),
    .hdr_busy       (hdr_busy),
    .ctrl_busy      (ctrl_busy),
    .ctrl_rd_valid  (ctrl_rd_valid),
    .ctrl_rd_data   (ctrl_rd_data),
    .ctrl_cmd_valid (ctrl_cmd_valid),
    .ctrl_cmd_wr    (ctrl_cmd_wr),
    .ctrl_addr      (ctrl_addr),
    .ctrl_wr_data   (ctrl_wr_data),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  cmd_t          cmd_q[$];
  logic [DW-1:0] rdq[$];
  int            checks = 0;
  int            failures = 0;
  int            rv_seen = 0;
  cmd_t          mon_e;
  logic [DW-1:0] mon_d;

  // controller model
  logic          force_busy = 1'b0;
  logic          stray_rv = 1'b0;
  logic          mdl_rv = 1'b0;
  logic [DW-1:0] mdl_rd = '0;
  logic [DW-1:0] rv_data = '0;
  int            rd_lat = 3;
  int            rv_cnt = 0;
  int            bz_cnt = 0;

  assign ctrl_busy     = force_busy | (bz_cnt != 0);
  assign ctrl_rd_valid = mdl_rv | stray_rv;
  assign ctrl_rd_data  = mdl_rd;

  task automatic check(string name, logic [DW-1:0] act,
                       logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(logic wr, logic [AW-1:0] a, logic [DW-1:0] d);
    cmd_t c;
    c.wr   = wr;
    c.addr = a;
    c.data = d;
    cmd_q.push_back(c);
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while ((cmd_q.size() != 0 || rdq.size() != 0 || rd_busy ||
            cam_busy || hdr_busy || ctrl_busy) && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL %s timeout act=busy exp=idle cmdq=%0d rdq=%0d",
               name, cmd_q.size(), rdq.size());
    end
    repeat (6) tick();
  endtask

  always @(negedge clk) begin
    mdl_rv = 1'b0;
    if (rv_cnt != 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        mdl_rv = 1'b1;
        mdl_rd = rv_data;
      end
    end
    if (bz_cnt != 0) bz_cnt--;
    if (ctrl_cmd_valid === 1'b1) begin
      if (ctrl_cmd_wr === 1'b1) begin
        bz_cnt = 3;
      end else begin
        rv_cnt  = rd_lat;
        rv_data = DW'(ctrl_addr);
      end
    end
  end

  always @(negedge clk) begin
    if (ctrl_cmd_valid === 1'b1) begin
      if (cmd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_cmd act=wr%0b addr=%0h exp=none",
                 ctrl_cmd_wr, ctrl_addr);
      end else begin
        mon_e = cmd_q.pop_front();
        check("cmd_wr", DW'(ctrl_cmd_wr), DW'(mon_e.wr));
        check("cmd_addr", DW'(ctrl_addr), DW'(mon_e.addr));
        check("cmd_data", ctrl_wr_data, mon_e.data);
      end
    end
    if (rd_valid === 1'b1) begin
      rv_seen++;
      if (rdq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rd_valid act=%0h exp=none", rd_data);
      end else begin
        mon_d = rdq.pop_front();
        check("rd_data", rd_data, mon_d);
      end
    end
  end

  initial begin
    int base;
    rst_n       = 1'b0;
    rd_req      = 1'b0;
    rd_addr     = '0;
    cam_wr_req  = 1'b0;
    cam_wr_addr = '0;
    cam_wr_data = '0;
    hdr_wr_req  = 1'b0;
    hdr_wr_addr = '0;
    hdr_wr_data = '0;
    repeat (3) tick();

    check("rst_rd_busy", DW'(rd_busy), DW'(0));
    check("rst_cam_busy", DW'(cam_busy), DW'(0));
    check("rst_hdr_busy", DW'(hdr_busy), DW'(0));
    check("rst_rd_valid", DW'(rd_valid), DW'(0));
    check("rst_rd_data", rd_data, DW'(0));
    check("rst_cmd_valid", DW'(ctrl_cmd_valid), DW'(0));
    check("rst_cmd_wr", DW'(ctrl_cmd_wr), DW'(0));
    check("rst_addr", DW'(ctrl_addr), DW'(0));
    check("rst_wdata", ctrl_wr_data, DW'(0));
    check("rst_ovf", DW'(overflow), DW'(0));
    rst_n = 1'b1;
    tick();

    // simultaneous writers: cam, hdr, cam, hdr
    for (int r = 0; r < 2; r++) begin
      push_cmd(1'b1, AW'(32'h200 + r), {4{32'(32'hC0DE0000 + r)}});
      push_cmd(1'b1, AW'(32'h300 + r), {4{32'(32'hBEEF0000 + r)}});
      cam_wr_addr = AW'(32'h200 + r);
      cam_wr_data = {4{32'(32'hC0DE0000 + r)}};
      hdr_wr_addr = AW'(32'h300 + r);
      hdr_wr_data = {4{32'(32'hBEEF0000 + r)}};
      cam_wr_req  = 1'b1;
      hdr_wr_req  = 1'b1;
      tick();
      cam_wr_req = 1'b0;
      hdr_wr_req = 1'b0;
      wait_idle("rr_pair");
    end
    check("rr_ovf", DW'(overflow), DW'(0));

    // single hdr write: 2-cycle latency, busy exactly 2 cycles
    push_cmd(1'b1, 25'hE1000, {16{8'hA5}});
    hdr_wr_addr = 25'hE1000;
    hdr_wr_data = {16{8'hA5}};
    hdr_wr_req  = 1'b1;
    tick();
    hdr_wr_req = 1'b0;
    check("lat_busy_c1", DW'(hdr_busy), DW'(1));
    check("lat_cv_c1", DW'(ctrl_cmd_valid), DW'(0));
    tick();
    check("lat_busy_c2", DW'(hdr_busy), DW'(1));
    check("lat_cv_c2", DW'(ctrl_cmd_valid), DW'(1));
    tick();
    check("lat_busy_c3", DW'(hdr_busy), DW'(0));
    check("lat_cv_c3", DW'(ctrl_cmd_valid), DW'(0));
    wait_idle("single_wr");

    // read streak cap with cam write pending
    for (int i = 0; i < 4; i++) begin
      push_cmd(1'b0, AW'(32'h100 + i), '0);
      rdq.push_back(DW'(32'h100 + i));
    end
    push_cmd(1'b1, 25'h400, {4{32'h0CA0CA0C}});
    for (int i = 4; i < 6; i++) begin
      push_cmd(1'b0, AW'(32'h100 + i), '0);
      rdq.push_back(DW'(32'h100 + i));
    end
    rd_addr     = 25'h100;
    cam_wr_addr = 25'h400;
    cam_wr_data = {4{32'h0CA0CA0C}};
    rd_req      = 1'b1;
    cam_wr_req  = 1'b1;
    tick();
    rd_req     = 1'b0;
    cam_wr_req = 1'b0;
    for (int i = 1; i < 6; i++) begin
      int n = 0;
      while (rd_busy && n < 100) begin
        tick();
        n++;
      end
      rd_addr = AW'(32'h100 + i);
      rd_req  = 1'b1;
      tick();
      rd_req = 1'b0;
    end
    wait_idle("streak");
    check("streak_ovf", DW'(overflow), DW'(0));

    // hdr drop while controller busy
    force_busy  = 1'b1;
    hdr_wr_addr = 25'h3000;
    hdr_wr_data = {4{32'hD1D1D1D1}};
    hdr_wr_req  = 1'b1;
    tick();
    hdr_wr_req = 1'b0;
    tick();
    hdr_wr_addr = 25'h3001;
    hdr_wr_data = {4{32'hD2D2D2D2}};
    hdr_wr_req  = 1'b1;
    tick();
    hdr_wr_req = 1'b0;
    tick();
    check("drop_ovf", DW'(overflow), DW'(3'b100));
    repeat (4) tick();
    check("drop_held", DW'(hdr_busy), DW'(1));
    push_cmd(1'b1, 25'h3000, {4{32'hD1D1D1D1}});
    force_busy = 1'b0;
    wait_idle("drop");
    check("drop_ovf_sticky", DW'(overflow), DW'(3'b100));

    // read return and stray ctrl_rd_valid
    rd_lat = 6;
    push_cmd(1'b0, 25'h1234, '0);
    rdq.push_back(DW'(32'h1234));
    base    = rv_seen;
    rd_addr = 25'h1234;
    rd_req  = 1'b1;
    tick();
    rd_req = 1'b0;
    wait_idle("read");
    check("read_once", DW'(rv_seen - base), DW'(1));
    check("read_data", rd_data, DW'(32'h1234));
    base     = rv_seen;
    stray_rv = 1'b1;
    tick();
    stray_rv = 1'b0;
    repeat (4) tick();
    check("stray_rv", DW'(rv_seen - base), DW'(0));

    // reset during WAIT_RD with a cam write buffered
    rd_lat = 12;
    push_cmd(1'b0, 25'h55, '0);
    rd_addr = 25'h55;
    rd_req  = 1'b1;
    tick();
    rd_req = 1'b0;
    repeat (4) tick();
    check("mid_issued", DW'(cmd_q.size()), DW'(0));
    cam_wr_addr = 25'h777;
    cam_wr_data = {4{32'h77777777}};
    cam_wr_req  = 1'b1;
    tick();
    cam_wr_req = 1'b0;
    check("mid_cam_held", DW'(cam_busy), DW'(1));
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("mid_rd_busy", DW'(rd_busy), DW'(0));
    check("mid_cam_busy", DW'(cam_busy), DW'(0));
    check("mid_hdr_busy", DW'(hdr_busy), DW'(0));
    check("mid_ovf", DW'(overflow), DW'(0));
    check("mid_rd_data", rd_data, DW'(0));
    check("mid_cv", DW'(ctrl_cmd_valid), DW'(0));
    check("mid_addr", DW'(ctrl_addr), DW'(0));
    base = rv_seen;
    repeat (12) tick();
    check("mid_no_rv", DW'(rv_seen - base), DW'(0));

    // FSM back in IDLE: fresh write issues with minimum latency
    push_cmd(1'b1, 25'h9999, {4{32'h33333333}});
    hdr_wr_addr = 25'h9999;
    hdr_wr_data = {4{32'h33333333}};
    hdr_wr_req  = 1'b1;
    tick();
    hdr_wr_req = 1'b0;
    check("post_cv_c1", DW'(ctrl_cmd_valid), DW'(0));
    tick();
    check("post_cv_c2", DW'(ctrl_cmd_valid), DW'(1));
    wait_idle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
